// File: rtl/seg_pattern_decoder_pkg.sv
// Shared 7-segment definitions: active-low patterns for hex digits 0..F
// (also used by the display encoder) and the decoder state encoding.
package seg_pattern_decoder_pkg;

  localparam logic [7:0] DP_OFF = 8'h80;

  // Indexed by nibble value; bit7 (dp) is held off in every entry.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    ST_LO,
    ST_HI,
    ST_OUT
  } state_e;

  function automatic logic [7:0] dp_off(input logic [7:0] pat);
    return pat | DP_OFF;
  endfunction

endpackage

// File: rtl/seg_pattern_decoder_seg7_to_nibble.sv
// Combinational active-low 7-segment pattern to nibble decoder.
// Unknown patterns, or a lit dp when STRICT_DP is set, report valid=0 with nibble 0.
module seg7_to_nibble
  import seg_pattern_decoder_pkg::*;
#(
  parameter int STRICT_DP = 1
) (
  input  logic [7:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b0;
    nibble = 4'h0;
    // Forcing dp off makes the table match on bits 6:0 only.
    for (int i = 0; i < 16; i++) begin
      if (dp_off(seg) == SEG_LUT[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
    if ((STRICT_DP != 0) && !seg[7]) begin
      valid  = 1'b0;
      nibble = 4'h0;
    end
  end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Decodes a stream of 7-segment patterns back into bytes (low nibble first)
// and presents them on a valid/ready interface; counts invalid patterns.
module seg_pattern_decoder
  import seg_pattern_decoder_pkg::*;
#(
  parameter int STRICT_DP = 1,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seg_in,
  input  logic             seg_in_valid,
  input  logic             seg_in_first,
  output logic             seg_in_ready,
  output logic [7:0]       byte_out,
  output logic             byte_err,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             resync_pulse,
  output logic [ERR_W-1:0] err_count
);

  state_e           state_q, state_d;
  logic [3:0]       lo_nib_q, lo_nib_d;
  logic             lo_err_q, lo_err_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_err_q, byte_err_d;
  logic             byte_valid_q, byte_valid_d;
  logic             ready_q, ready_d;
  logic             resync_q, resync_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic       dec_valid;
  logic [3:0] dec_nib;
  logic       accept, consume;

  seg7_to_nibble #(.STRICT_DP(STRICT_DP)) u_dec (
    .seg    (seg_in),
    .valid  (dec_valid),
    .nibble (dec_nib)
  );

  assign accept  = seg_in_valid && ready_q;
  assign consume = byte_valid_q && byte_ready;

  always_comb begin
    state_d      = state_q;
    lo_nib_d     = lo_nib_q;
    lo_err_d     = lo_err_q;
    byte_out_d   = byte_out_q;
    byte_err_d   = byte_err_q;
    byte_valid_d = byte_valid_q;
    resync_d     = 1'b0;
    err_d        = err_q;

    // Every accepted invalid pattern counts, even one later discarded by resync.
    if (accept && !dec_valid && (err_q != {ERR_W{1'b1}}))
      err_d = err_q + ERR_W'(1);

    case (state_q)
      ST_LO: begin
        if (accept) begin
          lo_nib_d = dec_nib;
          lo_err_d = !dec_valid;
          state_d  = ST_HI;
        end
      end
      ST_HI: begin
        if (accept) begin
          if (seg_in_first) begin
            lo_nib_d = dec_nib;
            lo_err_d = !dec_valid;
            resync_d = 1'b1;
          end else begin
            byte_out_d   = {dec_nib, lo_nib_q};
            byte_err_d   = lo_err_q | !dec_valid;
            byte_valid_d = 1'b1;
            state_d      = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (consume) begin
          byte_valid_d = 1'b0;
          state_d      = ST_LO;
        end
      end
      default: state_d = ST_LO;
    endcase

    ready_d = (state_d != ST_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LO;
      lo_nib_q     <= 4'h0;
      lo_err_q     <= 1'b0;
      byte_out_q   <= 8'h00;
      byte_err_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      resync_q     <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      lo_nib_q     <= lo_nib_d;
      lo_err_q     <= lo_err_d;
      byte_out_q   <= byte_out_d;
      byte_err_q   <= byte_err_d;
      byte_valid_q <= byte_valid_d;
      ready_q      <= ready_d;
      resync_q     <= resync_d;
      err_q        <= err_d;
    end
  end

  assign seg_in_ready = ready_q;
  assign byte_out     = byte_out_q;
  assign byte_err     = byte_err_q;
  assign byte_valid   = byte_valid_q;
  assign resync_pulse = resync_q;
  assign err_count    = err_q;

endmodule

// File: doc/seg_pattern_decoder.md
Name: seg_pattern_decoder

Overview:
- Inverse of the team's hex-to-7-segment display encoder.
- Accepts a stream of 8-bit active-low segment patterns, decodes each to a 4-bit nibble, and pairs them low-then-high into bytes.
- Decoded bytes go out on a valid/ready handshake.
- Sits on the loopback/self-check path of the serial-communication design: captured display drive values are turned back into the bytes that produced them.

Parameters:
- STRICT_DP, 1, when 1 a pattern with bit7=0 (decimal point lit) is invalid; when 0 bit7 is ignored during matching.
- ERR_W, 8, width of the saturating invalid-pattern counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  8  segment pattern, active-low, bit7=dp, bits6:0 = g..a.
- seg_in_valid  input  1  seg_in/seg_in_first are valid this cycle.
- seg_in_first  input  1  qualifies seg_in as the low nibble of a new byte (resync).
- seg_in_ready  output  1  block accepts a pattern this cycle.
- byte_out  output  8  decoded byte, {high nibble, low nibble}.
- byte_err  output  1  at least one of the two patterns in byte_out was invalid.
- byte_valid  output  1  byte_out/byte_err hold a byte.
- byte_ready  input  1  consumer accepts the byte.
- resync_pulse  output  1  one-cycle pulse when seg_in_first discards a pending low nibble.
- err_count  output  ERR_W  saturating count of invalid patterns.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - byte_out=0, byte_err=0, byte_valid=0, resync_pulse=0, err_count=0.
  - State = LO, so seg_in_ready=1.
- Decode table (pattern -> nibble), bits6:0 compared with bit7=1:
  - C0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, F8->7
  - 80->8, 90->9, 88->A, 83->B, C6->C, A1->D, 86->E, 8E->F
  - Any other pattern is invalid: nibble decodes to 0 and err_count increments, saturating at all-ones.
- Handshake:
  - A pattern is accepted on a rising edge with seg_in_valid && seg_in_ready.
  - A byte is consumed on a rising edge with byte_valid && byte_ready.
- State machine:
  - LO (seg_in_ready=1): on accept, store low nibble and its invalid flag, go to HI. seg_in_first is irrelevant in LO.
  - HI (seg_in_ready=1):
    - Accept with seg_in_first=0: combine into byte_out, byte_err = OR of both invalid flags, byte_valid=1, go to OUT.
    - Accept with seg_in_first=1: discard the pending low nibble, store this pattern as the new low nibble, stay in HI, pulse resync_pulse for exactly one cycle.
  - OUT (seg_in_ready=0, byte_valid=1): byte_out/byte_err stable until consumed. On consume: byte_valid=0, go to LO.
- Latency and throughput:
  - byte_valid rises the cycle after the high-nibble accept edge.
  - Minimum 3 cycles per byte with byte_ready tied high.
- err_count:
  - Increments on the accept edge of each invalid pattern, including a low nibble later discarded by resync.
  - Does not wrap.
- Simultaneous events:
  - OUT holds seg_in_ready=0, so an accept and a consume never coincide.
  - An invalid pattern arriving with seg_in_first still counts.
- Reset mid-operation: any pending nibble or held byte is dropped; outputs return to reset values immediately, without waiting for clk.

Decomposition:
- Shared package holds:
  - the 16 segment pattern constants, also to be reused by the display encoder;
  - the state enum LO/HI/OUT;
  - the function/constant for DP_OFF mask = 8'h80.
- One natural sub-module: seg7_to_nibble, a combinational 8->{valid,4} decoder honouring STRICT_DP, instantiated once.

Test Plan:
- Reset, then send C0 and F9 with byte_ready=1 -> byte_out=8'h10, byte_err=0, byte_valid for one cycle, err_count=0.
- Send 8E then 86, byte_ready=0 for 5 cycles -> byte_out=8'hEF held stable, seg_in_ready=0 throughout; byte_ready=1 -> byte_valid drops next cycle, seg_in_ready=1.
- Send 99; then A4 with seg_in_first=1; then B0 -> resync_pulse once, byte_out=8'h32, err_count=0.
- Send 40 (0 with dp lit) with STRICT_DP=1, then 92 -> byte_out=8'h50, byte_err=1, err_count=1; with STRICT_DP=0 -> byte_out=8'h50, byte_err=0.
- ERR_W=2: send 10 invalid FF patterns -> err_count saturates at 3, five bytes 8'h00 with byte_err=1.
- Assert rst while in HI after low nibble 80 -> byte_valid=0, seg_in_ready=1; then send C6, A1 -> byte_out=8'hDC (no stale 8).
